// File: rtl/bcd_subtractor_serial_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bcd_subtractor_serial_if : request/result bundle for the serial BCD    |
// | subtractor.                                          Revision: 1.0     |
// +-----------------------------------------------------------------------+
interface bcd_subtractor_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   minuend;
  logic [4*DIGITS-1:0]   subtrahend;
  logic [4*DIGITS-1:0]   difference;
  logic                  negative;
  logic                  invalid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, minuend, subtrahend,
    input  difference, negative, invalid, busy, done
  );

  modport slave (
    input  start, minuend, subtrahend,
    output difference, negative, invalid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bcd_subtractor_serial.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bcd_subtractor_serial : digit-serial |A-B| on packed BCD, LSD first,   |
// | with sign and invalid-digit flags.                    Revision: 1.0    |
// +-----------------------------------------------------------------------+
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  bcd_subtractor_serial_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [W-1:0]    work, work_next;
  logic [W-1:0]    diff_reg, diff_next;
  logic [IW-1:0]   idx, idx_next;
  logic            borrow, borrow_next;
  logic            neg_reg, neg_next;
  logic            inv_reg, inv_next;

  logic            bad_digit;
  logic            last_digit;
  logic [3:0]      dig_a, dig_b, dig_r;
  logic [4:0]      dig_t;
  logic            dig_borrow;
  logic [W-1:0]    work_shifted;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.minuend[4*i +: 4] > 4'd9 || bus.subtrahend[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  // Operands and result shift right one nibble per step, so the active
  // digit is always nibble 0 and the finished result lands in place.
  always_comb begin
    dig_a = a_reg[3:0];
    dig_b = b_reg[3:0];
    if (state == NEG) begin
      dig_a = 4'd0;
      dig_b = work[3:0];
    end
    dig_t        = {1'b0, dig_a} - {1'b0, dig_b} - {4'd0, borrow};
    dig_borrow   = dig_t[4];
    dig_r        = dig_borrow ? (dig_t[3:0] + 4'd10) : dig_t[3:0];
    work_shifted = (work >> 4) | (W'(dig_r) << (W - 4));
  end

  assign last_digit = (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      diff_reg <= '0;
      idx      <= '0;
      borrow   <= 1'b0;
      neg_reg  <= 1'b0;
      inv_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      a_reg    <= a_next;
      b_reg    <= b_next;
      work     <= work_next;
      diff_reg <= diff_next;
      idx      <= idx_next;
      borrow   <= borrow_next;
      neg_reg  <= neg_next;
      inv_reg  <= inv_next;
    end
  end

  always_comb begin
    state_next  = state;
    a_next      = a_reg;
    b_next      = b_reg;
    work_next   = work;
    diff_next   = diff_reg;
    idx_next    = idx;
    borrow_next = borrow;
    neg_next    = neg_reg;
    inv_next    = inv_reg;

    case (state)
      IDLE: begin
        if (bus.start) begin
          a_next      = bus.minuend;
          b_next      = bus.subtrahend;
          work_next   = '0;
          idx_next    = '0;
          borrow_next = 1'b0;
          if (bad_digit) begin
            state_next = DONE;
            diff_next  = '0;
            neg_next   = 1'b0;
            inv_next   = 1'b1;
          end else begin
            state_next = SUB;
          end
        end
      end

      SUB: begin
        a_next      = a_reg >> 4;
        b_next      = b_reg >> 4;
        work_next   = work_shifted;
        borrow_next = dig_borrow;
        idx_next    = idx + IW'(1);
        if (last_digit) begin
          idx_next = '0;
          if (dig_borrow) begin
            // Work register now holds the ten's complement; negate it.
            state_next  = NEG;
            borrow_next = 1'b0;
          end else begin
            state_next = DONE;
            diff_next  = work_shifted;
            neg_next   = 1'b0;
            inv_next   = 1'b0;
          end
        end
      end

      NEG: begin
        work_next   = work_shifted;
        borrow_next = dig_borrow;
        idx_next    = idx + IW'(1);
        if (last_digit) begin
          idx_next    = '0;
          borrow_next = 1'b0;
          state_next  = DONE;
          diff_next   = work_shifted;
          neg_next    = 1'b1;
          inv_next    = 1'b0;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.difference = diff_reg;
  assign bus.negative   = neg_reg;
  assign bus.invalid    = inv_reg;
  assign bus.busy       = (state == SUB) || (state == NEG);
  assign bus.done       = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_subtractor_serial.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bcd_subtractor_serial : randomized and directed self-checking bench |
// | against a decimal-arithmetic reference model.         Revision: 1.0    |
// +-----------------------------------------------------------------------+
module tb_bcd_subtractor_serial;

  localparam int D = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_subtractor_serial_if #(.DIGITS(D)) bus ();

  bcd_subtractor_serial #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model(input logic [15:0] m, input logic [15:0] s,
                                output logic [15:0] d, output logic n,
                                output logic inv, output int lat);
    int mi, si, mag;
    inv = 1'b0;
    mi = 0;
    si = 0;
    for (int i = D - 1; i >= 0; i--) begin
      if (m[4*i +: 4] > 4'd9 || s[4*i +: 4] > 4'd9) inv = 1'b1;
      mi = mi * 10 + int'(m[4*i +: 4]);
      si = si * 10 + int'(s[4*i +: 4]);
    end
    d = '0;
    n = 1'b0;
    if (inv) begin
      lat = 0;
    end else begin
      n   = (mi < si);
      mag = n ? (si - mi) : (mi - si);
      for (int i = 0; i < D; i++) begin
        d[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
      lat = n ? 2 * D : D;
    end
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Drives one request from an IDLE cycle and waits (bounded) for Done.
  // lat = edges after the accepting edge at which Done became visible.
  task automatic launch(input logic [15:0] m, input logic [15:0] s,
                        output int lat, output logic [15:0] d, output logic n,
                        output logic inv, output logic busy_ok,
                        output logic stable_ok, output logic done_gone);
    logic [15:0] prev;
    bus.minuend    = m;
    bus.subtrahend = s;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.minuend    = 16'($urandom);
    bus.subtrahend = 16'($urandom);
    prev      = bus.difference;
    lat       = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.difference !== prev) stable_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    d   = bus.difference;
    n   = bus.negative;
    inv = bus.invalid;
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    @(posedge clk); #1;
    done_gone = (bus.done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.minuend = '0;
    bus.subtrahend = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.difference !== 16'h0) begin errors++; $display("FAIL reset_diff: got %h expected 0000", bus.difference); end
    checks++; if (bus.negative !== 1'b0) begin errors++; $display("FAIL reset_neg: got %b expected 0", bus.negative); end
    checks++; if (bus.invalid !== 1'b0) begin errors++; $display("FAIL reset_inv: got %b expected 0", bus.invalid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_cases();
    logic [15:0] m [2];
    logic [15:0] s [2];
    logic [15:0] d, ed;
    logic n, inv, en, einv, bok, sok, dg;
    int lat, elat;
    m[0] = 16'h5321; s[0] = 16'h1234;
    m[1] = 16'h1234; s[1] = 16'h5321;
    for (int k = 0; k < 2; k++) begin
      model(m[k], s[k], ed, en, einv, elat);
      launch(m[k], s[k], lat, d, n, inv, bok, sok, dg);
      checks++; if (lat !== elat) begin errors++; $display("FAIL plan%0d_latency: got %0d expected %0d", k, lat, elat); end
      checks++; if (d !== ed) begin errors++; $display("FAIL plan%0d_diff: got %h expected %h", k, d, ed); end
      checks++; if (n !== en) begin errors++; $display("FAIL plan%0d_neg: got %b expected %b", k, n, en); end
      checks++; if (inv !== 1'b0) begin errors++; $display("FAIL plan%0d_inv: got %b expected 0", k, inv); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL plan%0d_busy: got %b expected 1", k, bok); end
      checks++; if (sok !== 1'b1) begin errors++; $display("FAIL plan%0d_diff_stable: got %b expected 1", k, sok); end
      checks++; if (dg !== 1'b1) begin errors++; $display("FAIL plan%0d_done_one_cycle: got %b expected 1", k, dg); end
    end
  endtask

  task automatic test_boundary();
    logic [15:0] m [4];
    logic [15:0] s [4];
    logic [15:0] xd [4];
    logic        xn [4];
    logic [15:0] d;
    logic n, inv, bok, sok, dg;
    int lat;
    m[0] = 16'h0000; s[0] = 16'h9999; xd[0] = 16'h9999; xn[0] = 1'b1;
    m[1] = 16'h9999; s[1] = 16'h0001; xd[1] = 16'h9998; xn[1] = 1'b0;
    m[2] = 16'h0500; s[2] = 16'h0500; xd[2] = 16'h0000; xn[2] = 1'b0;
    m[3] = 16'h1000; s[3] = 16'h0001; xd[3] = 16'h0999; xn[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      launch(m[k], s[k], lat, d, n, inv, bok, sok, dg);
      checks++; if (d !== xd[k]) begin errors++; $display("FAIL boundary%0d_diff: got %h expected %h", k, d, xd[k]); end
      checks++; if (n !== xn[k]) begin errors++; $display("FAIL boundary%0d_neg: got %b expected %b", k, n, xn[k]); end
      checks++; if (lat !== (xn[k] ? 2 * D : D)) begin errors++; $display("FAIL boundary%0d_latency: got %0d expected %0d", k, lat, xn[k] ? 2 * D : D); end
    end
  endtask

  task automatic test_invalid();
    logic [15:0] d;
    logic n, inv, bok, sok, dg;
    int lat;
    launch(16'h12A4, 16'h0001, lat, d, n, inv, bok, sok, dg);
    checks++; if (lat !== 0) begin errors++; $display("FAIL invalid_latency: got %0d expected 0", lat); end
    checks++; if (inv !== 1'b1) begin errors++; $display("FAIL invalid_flag: got %b expected 1", inv); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL invalid_diff: got %h expected 0000", d); end
    checks++; if (n !== 1'b0) begin errors++; $display("FAIL invalid_neg: got %b expected 0", n); end
    checks++; if (bus.invalid !== 1'b1) begin errors++; $display("FAIL invalid_hold: got %b expected 1", bus.invalid); end
    launch(16'h0042, 16'h0017, lat, d, n, inv, bok, sok, dg);
    checks++; if (inv !== 1'b0) begin errors++; $display("FAIL invalid_cleared: got %b expected 0", inv); end
    checks++; if (d !== 16'h0025) begin errors++; $display("FAIL invalid_next_diff: got %h expected 0025", d); end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    bus.minuend = 16'h5321;
    bus.subtrahend = 16'h1234;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    lat++;
    bus.minuend = 16'h0001;
    bus.subtrahend = 16'h0002;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== D) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", lat, D); end
    checks++; if (bus.difference !== 16'h4087) begin errors++; $display("FAIL ignored_diff: got %h expected 4087", bus.difference); end
    checks++; if (bus.negative !== 1'b0) begin errors++; $display("FAIL ignored_neg: got %b expected 0", bus.negative); end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignored_no_queued_op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m [3];
    logic [15:0] s [3];
    logic [15:0] ed;
    logic en, einv;
    int elat, cyc, k, guard;
    m[0] = 16'h0750; s[0] = 16'h0125;
    m[1] = 16'h0003; s[1] = 16'h0900;
    m[2] = 16'h4444; s[2] = 16'h4444;
    k = 0;
    bus.minuend = m[0];
    bus.subtrahend = s[0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    guard = 0;
    while (k < 3 && guard < 200) begin
      if (bus.done === 1'b1) begin
        model(m[k], s[k], ed, en, einv, elat);
        checks++; if (cyc !== elat) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", k, cyc, elat); end
        checks++; if (bus.difference !== ed) begin errors++; $display("FAIL b2b%0d_diff: got %h expected %h", k, bus.difference, ed); end
        checks++; if (bus.negative !== en) begin errors++; $display("FAIL b2b%0d_neg: got %b expected %b", k, bus.negative, en); end
        k++;
        if (k < 3) begin
          bus.minuend = m[k];
          bus.subtrahend = s[k];
        end else begin
          bus.start = 1'b0;
        end
        cyc = -2;
      end
      @(posedge clk); #1;
      cyc++;
      guard++;
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", k); end
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    logic n, inv, bok, sok, dg;
    int lat, seen;
    bus.minuend = 16'h1234;
    bus.subtrahend = 16'h5321;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.difference !== 16'h0) begin errors++; $display("FAIL areset_diff: got %h expected 0000", bus.difference); end
    checks++; if (bus.negative !== 1'b0) begin errors++; $display("FAIL areset_neg: got %b expected 0", bus.negative); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", bus.done); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL areset_no_done: got %0d expected 0", seen); end
    launch(16'h0050, 16'h0100, lat, d, n, inv, bok, sok, dg);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL areset_fresh_diff: got %h expected 0050", d); end
    checks++; if (n !== 1'b1) begin errors++; $display("FAIL areset_fresh_neg: got %b expected 1", n); end
    checks++; if (lat !== 2 * D) begin errors++; $display("FAIL areset_fresh_latency: got %0d expected %0d", lat, 2 * D); end
  endtask

  task automatic test_random();
    logic [15:0] m, s, d, ed;
    logic n, inv, en, einv, bok, sok, dg;
    int lat, elat;
    for (int k = 0; k < 40; k++) begin
      m = rand_bcd();
      s = rand_bcd();
      if ($urandom_range(0, 7) == 0) m[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if (k % 10 == 3) s = m;
      model(m, s, ed, en, einv, elat);
      launch(m, s, lat, d, n, inv, bok, sok, dg);
      checks++; if (d !== ed) begin errors++; $display("FAIL rand%0d_diff: %h-%h got %h expected %h", k, m, s, d, ed); end
      checks++; if (n !== en) begin errors++; $display("FAIL rand%0d_neg: %h-%h got %b expected %b", k, m, s, n, en); end
      checks++; if (inv !== einv) begin errors++; $display("FAIL rand%0d_inv: %h-%h got %b expected %b", k, m, s, inv, einv); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency: %h-%h got %0d expected %0d", k, m, s, lat, elat); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_plan_cases();
    test_boundary();
    test_invalid();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
